writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
Write-back stage of the five-stage pipeline. It consumes the MEM/WB pipeline register outputs, selects the result and destination register, and commits the result into a 32x32 general register file. Two combinational read ports with write-through bypass serve the ID stage. It also keeps a retired-instruction counter, a last-write trace and a sticky illegal-type flag for on-board debug display.

Parameters:
NREGS, 32, number of architectural registers; register 0 is hardwired to zero.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
WB_Inst  input  32  instruction word from MEM/WB; rt = [20:16], rd = [15:11].
WB_NewPC  input  32  PC+4 of the instruction; link value for JAL.
WB_ALUOutput  input  32  ALU result.
WB_MemData  input  32  load data.
WB_InstNum  input  4  instruction tag; latched into the trace.
WB_InstType  input  4  instruction class; encoding is given under Behaviour.
ReadAddrA  input  5  ID read port A address.
ReadAddrB  input  5  ID read port B address.
ReadDataA  output  32  port A data, combinational.
ReadDataB  output  32  port B data, combinational.
RetiredCount  output  CNT_W  number of committed non-bubble instructions.
LastWriteValid  output  1  one-cycle pulse, high in the cycle after a register write.
LastWriteAddr  output  5  destination of the most recent register write.
LastWriteData  output  32  data of the most recent register write.
LastInstNum  output  4  WB_InstNum of the most recently retired instruction.
IllegalType  output  1  sticky flag; set on an undefined InstType.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high, sampled only on the rising edge of `clock`.
- InstType decode:
  - 0 = bubble: no write, not counted.
  - 1 = R-type: dest rd, data ALUOutput.
  - 2 = I-type ALU: dest rt, data ALUOutput.
  - 3 = load: dest rt, data MemData.
  - 4 = store, 5 = branch, 7 = jump: no write, counted.
  - 6 = JAL: dest 31, data NewPC.
  - 8..15 = illegal: no write, not counted, sets IllegalType.
- Write enable (combinational): WE = (type is 1, 2, 3 or 6) AND (dest != 0). A write to register 0 is dropped, but the instruction still counts as retired.
- Commit: when WE is high, regs[dest] <= data at the rising edge. There is exactly one write per cycle, so no write conflicts exist.
- Read ports:
  - ReadDataX = 0 if ReadAddrX == 0.
  - Otherwise, if WE is high and ReadAddrX == dest, ReadDataX = the current write data (same-cycle bypass).
  - Otherwise ReadDataX = regs[ReadAddrX].
  - Both ports apply this independently; both may hit the bypass in the same cycle.
- RetiredCount: increments by 1 at each edge where InstType is in 1..7. Wraps from 2^CNT_W-1 to 0 with no flag.
- Trace:
  - LastWriteValid <= WE every cycle.
  - On WE: LastWriteAddr <= dest and LastWriteData <= data; otherwise both hold.
  - LastInstNum <= WB_InstNum whenever InstType is in 1..7; otherwise it holds.
- IllegalType: set at the edge where InstType >= 8. It stays set until reset. The offending instruction has no other effect.
- Latency: data is visible via the bypass in the same cycle and via the array from the next cycle. All debug outputs update one cycle after the edge that commits the instruction.
- Reset: when reset is high at an edge, all registers[1..31] are cleared to 0. RetiredCount, LastWriteValid, LastWriteAddr, LastWriteData, LastInstNum and IllegalType all go to 0. Any write presented in that cycle is discarded.
- Read ports stay combinational during reset. The bypass is suppressed while reset is high, so a port reads the array value rather than the pending write data.
- Reset mid-stream: the first instruction after reset deasserts is processed normally.
- No X propagation: regs[0] is never written and always reads 0.

Test Plan:
1. Reset, then R-type with Inst rd=5 and ALUOutput=0x1234_5678 -> next cycle ReadAddrA=5 gives 0x12345678; LastWriteValid=1, LastWriteAddr=5; RetiredCount=1.
2. Load with rt=9 and MemData=0xDEADBEEF, with ReadAddrB=9 in the same cycle -> ReadDataB=0xDEADBEEF combinationally (bypass), before the edge.
3. JAL with NewPC=0x0000_0040 -> reg31=0x40. Then store, branch, jump, bubble -> RetiredCount rises by 3 only, and the trace still shows addr 31 / 0x40.
4. I-type with rt=0 and ALUOutput=0xFFFF_FFFF -> reg0 still reads 0, LastWriteValid stays 0, RetiredCount increments.
5. InstType=0xA with ALUOutput=7 -> no write, count unchanged, IllegalType=1 and it stays 1 through 10 more valid instructions until reset.
6. Preload RetiredCount to near wrap via 2^CNT_W retirements (reduce CNT_W=4 in the bench): 16 retirements -> 0. Then assert reset in the same cycle as a write to reg 3 -> reg3=0 and all outputs are 0 next cycle.

Source files
------------

// File: rtl/writeback_regfile.sv
// Write-back stage: decodes MEM/WB results and commits them into a 32x32 register file.
// Latency: writes visible on the read ports same cycle (bypass), in the array next cycle; debug outputs one cycle after commit.
// Backpressure: none; one instruction is accepted every cycle, there is no stall path.
//
// Ports:
//   clock, reset           - system clock, synchronous active-high reset
//   WB_Inst                - instruction word (rt = [20:16], rd = [15:11])
//   WB_NewPC               - PC+4, used as the JAL link value
//   WB_ALUOutput           - ALU result
//   WB_MemData             - load data
//   WB_InstNum             - instruction tag, latched into the trace
//   WB_InstType            - instruction class (0 bubble, 1..7 legal, 8..15 illegal)
//   ReadAddrA/B            - ID-stage read addresses
//   ReadDataA/B            - combinational read data with same-cycle bypass
//   RetiredCount           - count of committed non-bubble legal instructions
//   LastWriteValid/Addr/Data - trace of the most recent register write
//   LastInstNum            - tag of the most recently retired instruction
//   IllegalType            - sticky flag, set by an undefined instruction class

module writeback_regfile #(
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      WB_Inst,
    input  logic [31:0]      WB_NewPC,
    input  logic [31:0]      WB_ALUOutput,
    input  logic [31:0]      WB_MemData,
    input  logic [3:0]       WB_InstNum,
    input  logic [3:0]       WB_InstType,
    input  logic [4:0]       ReadAddrA,
    input  logic [4:0]       ReadAddrB,
    output logic [31:0]      ReadDataA,
    output logic [31:0]      ReadDataB,
    output logic [CNT_W-1:0] RetiredCount,
    output logic             LastWriteValid,
    output logic [4:0]       LastWriteAddr,
    output logic [31:0]      LastWriteData,
    output logic [3:0]       LastInstNum,
    output logic             IllegalType
);

    // Instruction class encoding
    localparam logic [3:0] T_BUBBLE = 4'd0;
    localparam logic [3:0] T_RTYPE  = 4'd1;
    localparam logic [3:0] T_ITYPE  = 4'd2;
    localparam logic [3:0] T_LOAD   = 4'd3;
    localparam logic [3:0] T_JAL    = 4'd6;

    localparam logic [4:0] LINK_REG = 5'd31;

    // ------------------------------------------------------------------
    // Decode: destination, write data and instruction classification
    // ------------------------------------------------------------------
    logic [4:0]  inst_rt;
    logic [4:0]  inst_rd;
    logic        type_writes;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        byp_en;
    logic        is_retire;
    logic        is_illegal;

    assign inst_rt = WB_Inst[20:16];
    assign inst_rd = WB_Inst[15:11];

    // Only the register-selector fields of the instruction word matter here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{WB_Inst[31:21], WB_Inst[10:0]};

    always_comb begin
        type_writes = 1'b0;
        wr_addr     = 5'd0;
        wr_data     = 32'd0;
        case (WB_InstType)
            T_RTYPE: begin
                type_writes = 1'b1;
                wr_addr     = inst_rd;
                wr_data     = WB_ALUOutput;
            end
            T_ITYPE: begin
                type_writes = 1'b1;
                wr_addr     = inst_rt;
                wr_data     = WB_ALUOutput;
            end
            T_LOAD: begin
                type_writes = 1'b1;
                wr_addr     = inst_rt;
                wr_data     = WB_MemData;
            end
            T_JAL: begin
                type_writes = 1'b1;
                wr_addr     = LINK_REG;
                wr_data     = WB_NewPC;
            end
            default: begin
                type_writes = 1'b0;
                wr_addr     = 5'd0;
                wr_data     = 32'd0;
            end
        endcase
    end

    // Writes to r0 are dropped but the instruction still retires.
    assign wr_en      = type_writes && (wr_addr != 5'd0);
    // The pending write is discarded under reset, so it must not be bypassed either.
    assign byp_en     = wr_en && !reset;
    // Classes 1..7 retire; bit 3 set marks the illegal range 8..15.
    assign is_retire  = (WB_InstType != T_BUBBLE) && !WB_InstType[3];
    assign is_illegal = WB_InstType[3];

    // ------------------------------------------------------------------
    // Register array. Entry 0 is only ever cleared, never written.
    // ------------------------------------------------------------------
    logic [31:0] regs_q [NREGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with write-through bypass
    // ------------------------------------------------------------------
    always_comb begin
        ReadDataA = regs_q[ReadAddrA];
        if (ReadAddrA == 5'd0) begin
            ReadDataA = 32'd0;
        end else if (byp_en && (ReadAddrA == wr_addr)) begin
            ReadDataA = wr_data;
        end
    end

    always_comb begin
        ReadDataB = regs_q[ReadAddrB];
        if (ReadAddrB == 5'd0) begin
            ReadDataB = 32'd0;
        end else if (byp_en && (ReadAddrB == wr_addr)) begin
            ReadDataB = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Retire counter, write trace and illegal flag
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             lwv_q,  lwv_d;
    logic [4:0]       lwa_q,  lwa_d;
    logic [31:0]      lwd_q,  lwd_d;
    logic [3:0]       lin_q,  lin_d;
    logic             ill_q,  ill_d;

    always_comb begin
        cnt_d = cnt_q;
        lwv_d = wr_en;
        lwa_d = lwa_q;
        lwd_d = lwd_q;
        lin_d = lin_q;
        ill_d = ill_q;

        // Counter wraps silently at 2^CNT_W.
        if (is_retire) begin
            cnt_d = cnt_q + CNT_W'(1);
            lin_d = WB_InstNum;
        end
        if (wr_en) begin
            lwa_d = wr_addr;
            lwd_d = wr_data;
        end
        if (is_illegal) begin
            ill_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            lwv_q <= 1'b0;
            lwa_q <= 5'd0;
            lwd_q <= 32'd0;
            lin_q <= 4'd0;
            ill_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lwv_q <= lwv_d;
            lwa_q <= lwa_d;
            lwd_q <= lwd_d;
            lin_q <= lin_d;
            ill_q <= ill_d;
        end
    end

    assign RetiredCount   = cnt_q;
    assign LastWriteValid = lwv_q;
    assign LastWriteAddr  = lwa_q;
    assign LastWriteData  = lwd_q;
    assign LastInstNum    = lin_q;
    assign IllegalType    = ill_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   WB_Inst, WB_NewPC, WB_ALUOutput, WB_MemData;
    logic [3:0]    WB_InstNum, WB_InstType;
    logic [4:0]    ReadAddrA, ReadAddrB;
    logic [31:0]   ReadDataA, ReadDataB;
    logic [CW-1:0] RetiredCount;
    logic          LastWriteValid;
    logic [4:0]    LastWriteAddr;
    logic [31:0]   LastWriteData;
    logic [3:0]    LastInstNum;
    logic          IllegalType;

    writeback_regfile #(.NREGS(32), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .WB_Inst(WB_Inst), .WB_NewPC(WB_NewPC), .WB_ALUOutput(WB_ALUOutput),
        .WB_MemData(WB_MemData), .WB_InstNum(WB_InstNum), .WB_InstType(WB_InstType),
        .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
        .ReadDataA(ReadDataA), .ReadDataB(ReadDataB),
        .RetiredCount(RetiredCount), .LastWriteValid(LastWriteValid),
        .LastWriteAddr(LastWriteAddr), .LastWriteData(LastWriteData),
        .LastInstNum(LastInstNum), .IllegalType(IllegalType)
    );

    always #5 clock = ~clock;

    int nerr = 0;
    int nchk = 0;

    // ---------------- behavioural reference model ----------------
    logic [31:0] mreg [32];
    int          mcnt;
    logic        mlv;
    logic [4:0]  mla;
    logic [31:0] mld;
    logic [3:0]  mlin;
    logic        mill;

    // Destination/data of the instruction currently presented, from the class table.
    function automatic void model_target(output bit w, output logic [4:0] d, output logic [31:0] v);
        d = 5'd0;
        v = 32'd0;
        case (WB_InstType)
            4'd1: begin d = WB_Inst[15:11]; v = WB_ALUOutput; end
            4'd2: begin d = WB_Inst[20:16]; v = WB_ALUOutput; end
            4'd3: begin d = WB_Inst[20:16]; v = WB_MemData;   end
            4'd6: begin d = 5'd31;          v = WB_NewPC;     end
            default: ;
        endcase
        w = (WB_InstType inside {4'd1, 4'd2, 4'd3, 4'd6}) && (d != 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        bit w; logic [4:0] d; logic [31:0] v;
        model_target(w, d, v);
        if (a == 5'd0) return 32'd0;
        if (!reset && w && d == a) return v;
        return mreg[a];
    endfunction

    function automatic void model_commit();
        bit w; logic [4:0] d; logic [31:0] v;
        if (reset) begin
            foreach (mreg[i]) mreg[i] = 32'd0;
            mcnt = 0; mlv = 0; mla = 0; mld = 0; mlin = 0; mill = 0;
            return;
        end
        model_target(w, d, v);
        mlv = w;
        if (w) begin
            mreg[d] = v;
            mla = d;
            mld = v;
        end
        if (WB_InstType >= 4'd1 && WB_InstType <= 4'd7) begin
            mcnt = (mcnt + 1) % (1 << CW);
            mlin = WB_InstNum;
        end
        if (WB_InstType >= 4'd8) mill = 1'b1;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rt, input logic [4:0] rd);
        return {11'h0, rt, rd, 11'h0};
    endfunction

    task automatic drive(input logic r, input logic [3:0] t, input logic [31:0] inst,
                         input logic [31:0] np, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [3:0] n, input logic [4:0] a, input logic [4:0] b);
        reset = r; WB_InstType = t; WB_Inst = inst; WB_NewPC = np;
        WB_ALUOutput = alu; WB_MemData = mem; WB_InstNum = n;
        ReadAddrA = a; ReadAddrB = b;
    endtask

    // Commit one edge in both DUT and model, return at the falling edge.
    task automatic cycle();
        @(posedge clock);
        model_commit();
        @(negedge clock);
    endtask

    task automatic chk_reads_model(input string tag);
        chk({tag, ".rdA"}, ReadDataA, model_read(ReadAddrA));
        chk({tag, ".rdB"}, ReadDataB, model_read(ReadAddrB));
    endtask

    task automatic chk_outs_model(input string tag);
        chk({tag, ".cnt"}, 32'(RetiredCount), 32'(mcnt));
        chk({tag, ".lwv"}, 32'(LastWriteValid), 32'(mlv));
        chk({tag, ".lwa"}, 32'(LastWriteAddr), 32'(mla));
        chk({tag, ".lwd"}, LastWriteData, mld);
        chk({tag, ".lin"}, 32'(LastInstNum), 32'(mlin));
        chk({tag, ".ill"}, 32'(IllegalType), 32'(mill));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  typ;
        logic [31:0] inst, newpc, alu, mem;
        logic [3:0]  num;
        logic [4:0]  ra, rb;
        logic [31:0] ea, eb;      // read data before the edge
        logic [3:0]  ecnt;        // registered outputs after the edge
        logic        elv;
        logic [4:0]  ela;
        logic [31:0] eld;
        logic [3:0]  elin;
        logic        eill;
    } vec_t;

    vec_t tbl [13];

    initial begin
        drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 5'd0);
        foreach (mreg[i]) mreg[i] = 32'd0;
        mcnt = 0; mlv = 0; mla = 0; mld = 0; mlin = 0; mill = 0;

        //           typ    inst          newpc  alu            mem            num  ra  rb   ea             eb             cnt  lv  la  ld             lin  ill
        tbl[0]  = '{4'd1,  mk(0, 5),   32'h0, 32'h12345678, 32'h0,         4'd1, 5, 0,  32'h12345678, 32'h0,         4'd1, 1, 5,  32'h12345678, 4'd1, 0};
        tbl[1]  = '{4'd0,  mk(7, 7),   32'h0, 32'h1,        32'h2,         4'd2, 5, 0,  32'h12345678, 32'h0,         4'd1, 0, 5,  32'h12345678, 4'd1, 0};
        tbl[2]  = '{4'd3,  mk(9, 4),   32'h0, 32'h11,       32'hDEADBEEF,  4'd3, 5, 9,  32'h12345678, 32'hDEADBEEF,  4'd2, 1, 9,  32'hDEADBEEF,  4'd3, 0};
        tbl[3]  = '{4'd6,  mk(9, 5),   32'h40, 32'h99,      32'h0,         4'd4, 31, 9, 32'h40,        32'hDEADBEEF,  4'd3, 1, 31, 32'h40,        4'd4, 0};
        tbl[4]  = '{4'd4,  mk(9, 5),   32'h0, 32'h55,       32'h66,        4'd5, 31, 5, 32'h40,        32'h12345678, 4'd4, 0, 31, 32'h40,        4'd5, 0};
        tbl[5]  = '{4'd5,  mk(9, 5),   32'h0, 32'h55,       32'h66,        4'd6, 9, 31, 32'hDEADBEEF,  32'h40,        4'd5, 0, 31, 32'h40,        4'd6, 0};
        tbl[6]  = '{4'd7,  mk(9, 5),   32'h0, 32'h55,       32'h66,        4'd7, 0, 31, 32'h0,         32'h40,        4'd6, 0, 31, 32'h40,        4'd7, 0};
        tbl[7]  = '{4'd0,  mk(9, 5),   32'h0, 32'h55,       32'h66,        4'd8, 0, 31, 32'h0,         32'h40,        4'd6, 0, 31, 32'h40,        4'd7, 0};
        tbl[8]  = '{4'd2,  mk(0, 6),   32'h0, 32'hFFFFFFFF, 32'h0,         4'd9, 0, 0,  32'h0,         32'h0,         4'd7, 0, 31, 32'h40,        4'd9, 0};
        tbl[9]  = '{4'd2,  mk(12, 0),  32'h0, 32'h0000A5A5, 32'h0,         4'hA, 12, 0, 32'h0000A5A5,  32'h0,         4'd8, 1, 12, 32'h0000A5A5,  4'hA, 0};
        tbl[10] = '{4'hA,  mk(12, 12), 32'h0, 32'h7,        32'h7,         4'hB, 12, 12, 32'h0000A5A5, 32'h0000A5A5,  4'd8, 0, 12, 32'h0000A5A5,  4'hA, 1};
        tbl[11] = '{4'd1,  mk(0, 12),  32'h0, 32'h77,       32'h0,         4'hC, 12, 5, 32'h77,        32'h12345678, 4'd9, 1, 12, 32'h77,        4'hC, 1};
        tbl[12] = '{4'd1,  mk(0, 5),   32'h0, 32'hCAFE,     32'h0,         4'hD, 5, 5,  32'hCAFE,      32'hCAFE,      4'hA, 1, 5,  32'hCAFE,      4'hD, 1};

        // ---- reset ----
        @(negedge clock);
        cycle();
        cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd7, 5'd31);
        #1;
        chk("rst.rdA", ReadDataA, 32'd0);
        chk("rst.rdB", ReadDataB, 32'd0);
        chk("rst.cnt", 32'(RetiredCount), 32'd0);
        chk("rst.lwv", 32'(LastWriteValid), 32'd0);
        chk("rst.ill", 32'(IllegalType), 32'd0);
        chk("rst.lin", 32'(LastInstNum), 32'd0);

        // ---- directed table ----
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, tbl[i].typ, tbl[i].inst, tbl[i].newpc, tbl[i].alu, tbl[i].mem,
                  tbl[i].num, tbl[i].ra, tbl[i].rb);
            #1;
            chk($sformatf("v%0d.rdA", i), ReadDataA, tbl[i].ea);
            chk($sformatf("v%0d.rdB", i), ReadDataB, tbl[i].eb);
            cycle();
            chk($sformatf("v%0d.cnt", i), 32'(RetiredCount), 32'(tbl[i].ecnt));
            chk($sformatf("v%0d.lwv", i), 32'(LastWriteValid), 32'(tbl[i].elv));
            chk($sformatf("v%0d.lwa", i), 32'(LastWriteAddr), 32'(tbl[i].ela));
            chk($sformatf("v%0d.lwd", i), LastWriteData, tbl[i].eld);
            chk($sformatf("v%0d.lin", i), 32'(LastInstNum), 32'(tbl[i].elin));
            chk($sformatf("v%0d.ill", i), 32'(IllegalType), 32'(tbl[i].eill));
        end

        // ---- illegal flag stays set through 10 legal instructions ----
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'($urandom_range(1, 7)), $urandom, $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            #1;
            chk_reads_model("sticky");
            cycle();
            chk("sticky.ill", 32'(IllegalType), 32'd1);
            chk_outs_model("sticky");
        end

        // ---- counter wrap with CNT_W = 4 ----
        drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 5'd0);
        cycle();
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 4'd4, mk(5'd3, 5'd3), 32'd0, 32'd0, 32'd0, 4'(i), 5'd0, 5'd0);
            cycle();
        end
        chk("wrap.cnt15", 32'(RetiredCount), 32'd15);
        cycle();
        chk("wrap.cnt0", 32'(RetiredCount), 32'd0);
        chk("wrap.ill", 32'(IllegalType), 32'd0);

        // ---- reset in the same cycle as a write ----
        drive(1'b0, 4'd1, mk(5'd0, 5'd3), 32'd0, 32'h333, 32'd0, 4'd5, 5'd3, 5'd0);
        cycle();
        drive(1'b1, 4'd1, mk(5'd0, 5'd3), 32'd0, 32'h444, 32'd0, 4'd6, 5'd3, 5'd3);
        #1;
        chk("rstw.rdA_nobyp", ReadDataA, 32'h333);
        cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd3, 5'd0);
        #1;
        chk("rstw.reg3", ReadDataA, 32'd0);
        chk("rstw.cnt", 32'(RetiredCount), 32'd0);
        chk("rstw.lwv", 32'(LastWriteValid), 32'd0);
        chk("rstw.lwa", 32'(LastWriteAddr), 32'd0);
        chk("rstw.lwd", LastWriteData, 32'd0);
        chk("rstw.lin", 32'(LastInstNum), 32'd0);
        // First instruction after reset is processed normally.
        drive(1'b0, 4'd1, mk(5'd0, 5'd3), 32'd0, 32'h555, 32'd0, 4'd9, 5'd3, 5'd0);
        #1;
        chk("post.byp", ReadDataA, 32'h555);
        cycle();
        chk("post.cnt", 32'(RetiredCount), 32'd1);
        chk("post.lwa", 32'(LastWriteAddr), 32'd3);
        chk("post.lwd", LastWriteData, 32'h555);
        chk("post.lin", 32'(LastInstNum), 32'd9);

        // ---- randomized against the reference model ----
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  t;
            logic [31:0] inst;
            logic [4:0]  a, b;
            t    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            inst = $urandom;
            a    = ($urandom_range(0, 2) == 0) ? inst[15:11] : 5'($urandom_range(0, 31));
            b    = ($urandom_range(0, 2) == 0) ? inst[20:16] : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) b = 5'd31;
            drive(($urandom_range(0, 59) == 0), t, inst, $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 15)), a, b);
            #1;
            chk_reads_model("rnd");
            cycle();
            chk_outs_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
